// File: rtl/capi_reset_sequencer.sv
// Staged reset release for the CAPI card: stages leave reset in order 0..N-1, each after a
// guard delay and only once the previous stage reports ready; a stuck stage raises a sticky timeout.
module capi_reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter logic [9:0]  STAGE_DELAY = 10'd64,
    parameter logic [15:0] TIMEOUT     = 16'd4096,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SOFT_RESET_REQ,
    input  logic [NUM_STAGES-1:0] STAGE_READY,
    output logic [NUM_STAGES-1:0] STAGE_RESET,
    output logic                  ALL_READY,
    output logic                  TIMEOUT_ERR,
    output logic [3:0]            ERR_STAGE
);
    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_WAIT_DLY = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_DONE     = 3'd3,
        S_ERROR    = 3'd4
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(NUM_STAGES - 1);

    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic                   rst_sync_s;
    logic                   ready_sel_s;
    state_e                 state_q, state_d;
    logic [9:0]             dly_q, dly_d;
    logic [15:0]            tmo_q, tmo_d;
    logic [3:0]             idx_q, idx_d;
    logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
    logic                   all_ready_q, all_ready_d;
    logic                   tmo_err_q, tmo_err_d;
    logic [3:0]             err_stage_q, err_stage_d;

    // Reset release synchronizer: shifts zeros in once RESET drops.
    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    assign rst_sync_s = rst_sync_q[SYNC_STAGES-1];

    // Select the ready line of the stage currently being waited on.
    always_comb begin
        ready_sel_s = 1'b0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (idx_q == 4'(i)) begin
                ready_sel_s = STAGE_READY[i];
            end else begin
                ready_sel_s = ready_sel_s;
            end
        end
    end

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        tmo_d       = tmo_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        all_ready_d = all_ready_q;
        tmo_err_d   = tmo_err_q;
        err_stage_d = err_stage_q;

        // Soft re-sequence keeps the error record; only RESET clears it.
        if (rst_sync_s || SOFT_RESET_REQ) begin
            state_d     = S_HOLD;
            dly_d       = 10'd0;
            tmo_d       = 16'd0;
            idx_d       = 4'd0;
            stage_rst_d = '1;
            all_ready_d = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (dly_q == STAGE_DELAY - 10'd1) begin
                        stage_rst_d[0] = 1'b0;
                        idx_d          = 4'd0;
                        tmo_d          = 16'd0;
                        dly_d          = 10'd0;
                        state_d        = S_WAIT_RDY;
                    end else begin
                        dly_d = dly_q + 10'd1;
                    end
                end
                S_WAIT_RDY: begin
                    tmo_d = tmo_q + 16'd1;
                    if (ready_sel_s) begin
                        if (idx_q == LAST_IDX) begin
                            all_ready_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            dly_d   = 10'd0;
                            state_d = S_WAIT_DLY;
                        end
                    end else if (tmo_q == TIMEOUT - 16'd1) begin
                        tmo_err_d   = 1'b1;
                        err_stage_d = idx_q;
                        state_d     = S_ERROR;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end
                S_WAIT_DLY: begin
                    if (dly_q == STAGE_DELAY - 10'd1) begin
                        for (int i = 0; i < int'(NUM_STAGES); i++) begin
                            if (idx_q == 4'(i)) begin
                                stage_rst_d[i] = 1'b0;
                            end else begin
                                stage_rst_d[i] = stage_rst_d[i];
                            end
                        end
                        tmo_d   = 16'd0;
                        state_d = S_WAIT_RDY;
                    end else begin
                        dly_d = dly_q + 10'd1;
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_ERROR: state_d = S_ERROR;
                default: begin
                    state_d     = S_HOLD;
                    dly_d       = 10'd0;
                    stage_rst_d = '1;
                    all_ready_d = 1'b0;
                end
            endcase
        end
    end

    // Synchronizer flops: asserted asynchronously, released on the clock.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rst_sync_q <= '1;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_HOLD;
            dly_q       <= 10'd0;
            tmo_q       <= 16'd0;
            idx_q       <= 4'd0;
            stage_rst_q <= '1;
            all_ready_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            err_stage_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            all_ready_q <= all_ready_d;
            tmo_err_q   <= tmo_err_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign STAGE_RESET = stage_rst_q;
    assign ALL_READY   = all_ready_q;
    assign TIMEOUT_ERR = tmo_err_q;
    assign ERR_STAGE   = err_stage_q;

endmodule

// File: tb/tb_capi_reset_sequencer.sv
// Randomized bench for capi_reset_sequencer; expected outputs come from a per-scenario
// schedule of release/ready/timeout edge numbers computed arithmetically.
module tb_capi_reset_sequencer;
    localparam int NS   = 4;
    localparam int SD   = 8;
    localparam int TO   = 32;
    localparam int SYNC = 2;
    localparam int INF  = 32'h3fff_ffff;

    logic          CLK;
    logic          RESET;
    logic          SOFT_RESET_REQ;
    logic [NS-1:0] STAGE_READY;
    logic [NS-1:0] STAGE_RESET;
    logic          ALL_READY;
    logic          TIMEOUT_ERR;
    logic [3:0]    ERR_STAGE;

    capi_reset_sequencer #(
        .NUM_STAGES (NS),
        .STAGE_DELAY(10'd8),
        .TIMEOUT    (16'd32),
        .SYNC_STAGES(SYNC)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .SOFT_RESET_REQ(SOFT_RESET_REQ),
        .STAGE_READY   (STAGE_READY),
        .STAGE_RESET   (STAGE_RESET),
        .ALL_READY     (ALL_READY),
        .TIMEOUT_ERR   (TIMEOUT_ERR),
        .ERR_STAGE     (ERR_STAGE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int edge_n = 0;
    always @(posedge CLK) edge_n <= edge_n + 1;

    // Reference schedule: edge numbers at which each event happens.
    int lat [NS];
    int rel [NS];
    int rdy [NS];
    int drv [NS];
    int done_e, err_e, err_idx;
    int sticky_err, sticky_stage;
    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < NS; k++) begin
            rel[k] = INF; rdy[k] = INF; drv[k] = INF;
        end
        done_e = INF; err_e = INF; err_idx = 0;
        sticky_err = 0; sticky_stage = 0;
    endtask

    // Stage 0 is released SD edges after base; each later stage SD edges after the previous ready.
    task automatic plan(input int base);
        bit stop;
        stop = 1'b0;
        for (int k = 0; k < NS; k++) begin
            rel[k] = INF; rdy[k] = INF; drv[k] = INF;
        end
        done_e = INF; err_e = INF; err_idx = 0;
        rel[0] = base + SD;
        for (int k = 0; k < NS; k++) begin
            if (!stop) begin
                if (lat[k] > TO) begin
                    err_e   = rel[k] + TO;
                    err_idx = k;
                    stop    = 1'b1;
                end else begin
                    rdy[k] = rel[k] + ((lat[k] == 0) ? 1 : lat[k]);
                    drv[k] = (lat[k] == 0) ? 0 : rel[k] + lat[k];
                    if (k == NS - 1) done_e = rdy[k];
                    else rel[k+1] = rdy[k] + SD;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [NS-1:0] exp_rst;
        for (int k = 0; k < NS; k++) exp_rst[k] = (edge_n >= rel[k]) ? 1'b0 : 1'b1;
        check_val("stage_reset", 32'(STAGE_RESET), 32'(exp_rst));
        check_val("all_ready", 32'(ALL_READY), 32'(edge_n >= done_e));
        check_val("timeout_err", 32'(TIMEOUT_ERR), 32'((sticky_err != 0) || (edge_n >= err_e)));
        check_val("err_stage", 32'(ERR_STAGE), 32'((edge_n >= err_e) ? err_idx : sticky_stage));
    endtask

    task automatic drive_ready();
        for (int k = 0; k < NS; k++) STAGE_READY[k] = (edge_n + 1 >= drv[k]);
    endtask

    task automatic tick();
        drive_ready();
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic run_until(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic soft_req();
        SOFT_RESET_REQ = 1'b1;
        drive_ready();
        @(posedge CLK);
        #1;
        if (err_e < edge_n) begin
            sticky_err   = 1;
            sticky_stage = err_idx;
        end
        plan(edge_n);
        SOFT_RESET_REQ = 1'b0;
        check_outputs();
    endtask

    // Called 1 time unit after an edge; asserts RESET between edges.
    task automatic assert_reset();
        #2;
        RESET = 1'b1;
        #1;
        reset_model();
        check_outputs();
    endtask

    task automatic release_reset();
        #2;
        RESET = 1'b0;
        plan(edge_n + SYNC);
    endtask

    task automatic set_lats(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    task automatic rand_lats(input bit allow_err);
        for (int k = 0; k < NS; k++) lat[k] = $urandom_range(0, TO);
        if (allow_err && ($urandom_range(0, 3) == 0)) lat[$urandom_range(0, NS - 1)] = TO + 1 + $urandom_range(0, 3);
    endtask

    initial begin
        int stop_e, end_e;
        RESET          = 1'b1;
        SOFT_RESET_REQ = 1'b0;
        STAGE_READY    = '0;
        reset_model();
        #1;
        check_outputs();
        tick();
        tick();

        // Nominal sequence from power-on release.
        set_lats(3, 3, 3, 3);
        release_reset();
        run_until(done_e + 4);

        // Re-sequence from DONE with stage 2 stuck.
        set_lats(3, 3, 1000, 3);
        soft_req();
        run_until(err_e + 6);

        // Re-sequence from ERROR: stage 0 ready early, stage 1 ready on the last allowed edge.
        lat[0] = 0; lat[1] = TO; lat[2] = $urandom_range(1, 10); lat[3] = $urandom_range(1, 10);
        soft_req();
        run_until(done_e + 3);

        // Async RESET in the middle of the guard delay after stage 0.
        set_lats(3, 3, 3, 3);
        soft_req();
        run_until(rdy[0] + 3);
        assert_reset();
        tick();
        tick();
        release_reset();
        run_until(done_e + 3);

        // Random sequences, some cut short by a soft request.
        for (int it = 0; it < 10; it++) begin
            rand_lats(1'b1);
            soft_req();
            end_e = (done_e < INF) ? done_e : err_e;
            if ($urandom_range(0, 3) == 0) stop_e = edge_n + $urandom_range(1, end_e - edge_n);
            else stop_e = end_e + 2;
            run_until(stop_e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
